// File: rtl/team_06_sram_pkg.sv
// Shared types and helpers for the SRAM audio delay line and its bus initiator.
package team_06_sram_pkg;

    // Phase of an SRAM access: idle, holding a write request, holding a read request.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

    // The responder decodes a 13-bit word address; everything above is driven low.
    localparam int SRAM_AW = 13;

    // One-hot byte-lane enable for a byte offset inside a 32-bit word.
    function automatic logic [3:0] laneSelect(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Extract the byte at a given lane of a 32-bit word.
    function automatic logic [7:0] laneByte(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/team_06_sram_initiator.sv
// Generic single-access handshake engine for the SRAM responder.
// A request is latched, held stable until busy is seen, then released;
// a new request may be accepted in the same cycle the previous one completes.
module team_06_sram_initiator
    import team_06_sram_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        reqWr_i,
    input  logic        reqRd_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [31:0] sramAddress_o,
    output logic [31:0] sramWriteData_o,
    output logic        sramWriteEn_o,
    output logic        sramReadEn_o,
    output logic [3:0]  sramByteSelect_o,
    input  logic [31:0] sramReadData_i,
    input  logic        sramBusy_i
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        accept;

    // Request registers: everything the bus sees comes straight from these flops.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Completion is the first sampled busy; only then may a new request be latched.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        done_o  = (state_q != IDLE) && sramBusy_i;
        accept  = (state_q == IDLE) || done_o;
        if (accept) begin
            state_d = IDLE;
            if (reqWr_i) begin
                state_d = WR;
                addr_d  = addr_i;
                wdata_d = wdata_i;
                be_d    = be_i;
            end else if (reqRd_i) begin
                state_d = RD;
                addr_d  = addr_i;
                be_d    = be_i;
            end
        end
    end

    assign sramWriteEn_o    = (state_q == WR);
    assign sramReadEn_o     = (state_q == RD);
    assign sramAddress_o    = addr_q;
    assign sramWriteData_o  = wdata_q;
    assign sramByteSelect_o = be_q;
    assign rdata_o          = sramReadData_i;

endmodule

// File: rtl/team_06_sram_audio_delay.sv
// Echo/delay line: writes each audio sample into a circular byte buffer in SRAM
// and reads back the byte written delay_samples earlier.
module team_06_sram_audio_delay
    import team_06_sram_pkg::*;
#(
    parameter int BASE_WORD   = 0,
    parameter int DEPTH_WORDS = 1024,
    parameter int PTR_W       = $clog2(DEPTH_WORDS) + 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enable,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic [PTR_W-1:0] delay_samples,
    output logic [7:0]       sample_out,
    output logic             out_valid,
    output logic             overflow,
    output logic [31:0]      sram_address,
    output logic [31:0]      sram_write_data,
    output logic             sram_write_en,
    output logic             sram_read_en,
    output logic [3:0]       sram_byte_select,
    input  logic [31:0]      sram_read_data,
    input  logic             sram_busy
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic             pendValid_q, pendValid_d;
    logic [7:0]       pendData_q, pendData_d;
    logic [7:0]       sampleOut_q, sampleOut_d;
    logic             outValid_q, outValid_d;
    logic             overflow_q, overflow_d;

    logic             reqWr, reqRd, done;
    logic [31:0]      reqAddr, reqWdata, rdata;
    logic [3:0]       reqBe;
    logic [7:0]       wrSample;
    logic [PTR_W-1:0] rdPtrNext;

    // Byte pointer to word address: the low two bits pick the lane, the rest the word.
    function automatic logic [31:0] wordAddress(input logic [PTR_W-1:0] ptr);
        logic [SRAM_AW-1:0] word;
        word = SRAM_AW'(BASE_WORD) + SRAM_AW'(ptr[PTR_W-1:2]);
        return {{(32-SRAM_AW){1'b0}}, word};
    endfunction

    assign rdPtrNext = wrPtr_q - delay_samples;

    team_06_sram_initiator uInitiator (
        .clk              (clk),
        .nrst             (nrst),
        .reqWr_i          (reqWr),
        .reqRd_i          (reqRd),
        .addr_i           (reqAddr),
        .wdata_i          (reqWdata),
        .be_i             (reqBe),
        .done_o           (done),
        .rdata_o          (rdata),
        .sramAddress_o    (sram_address),
        .sramWriteData_o  (sram_write_data),
        .sramWriteEn_o    (sram_write_en),
        .sramReadEn_o     (sram_read_en),
        .sramByteSelect_o (sram_byte_select),
        .sramReadData_i   (sram_read_data),
        .sramBusy_i       (sram_busy)
    );

    // Sequencer state, pointers, pending slot and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            pendValid_q <= 1'b0;
            pendData_q  <= '0;
            sampleOut_q <= '0;
            outValid_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            pendValid_q <= pendValid_d;
            pendData_q  <= pendData_d;
            sampleOut_q <= sampleOut_d;
            outValid_q  <= outValid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Write-then-read per sample; strobes arriving while busy park in the one-deep slot.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        pendValid_d = pendValid_q;
        pendData_d  = pendData_q;
        sampleOut_d = sampleOut_q;
        outValid_d  = 1'b0;
        overflow_d  = overflow_q;
        reqWr       = 1'b0;
        reqRd       = 1'b0;
        reqAddr     = '0;
        reqWdata    = '0;
        reqBe       = '0;
        wrSample    = pendValid_q ? pendData_q : sample_in;

        case (state_q)
            IDLE: begin
                if (enable && (pendValid_q || sample_valid)) begin
                    reqWr       = 1'b1;
                    reqAddr     = wordAddress(wrPtr_q);
                    reqWdata    = {4{wrSample}};
                    reqBe       = laneSelect(wrPtr_q[1:0]);
                    state_d     = WR;
                    pendValid_d = pendValid_q && sample_valid;
                    if (pendValid_q && sample_valid) begin
                        pendData_d = sample_in;
                    end
                end
            end
            WR: begin
                if (done) begin
                    reqRd   = 1'b1;
                    reqAddr = wordAddress(rdPtrNext);
                    reqBe   = 4'hF;
                    rdPtr_d = rdPtrNext;
                    wrPtr_d = wrPtr_q + PTR_W'(1);
                    state_d = RD;
                end
            end
            RD: begin
                if (done) begin
                    sampleOut_d = laneByte(rdata, rdPtr_q[1:0]);
                    outValid_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enable && sample_valid && (state_q != IDLE)) begin
            if (pendValid_q) begin
                overflow_d = 1'b1;
            end else begin
                pendValid_d = 1'b1;
                pendData_d  = sample_in;
            end
        end

        if (!enable) begin
            pendValid_d = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    assign sample_out = sampleOut_q;
    assign out_valid  = outValid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_team_06_sram_audio_delay.sv
// Bench for the SRAM audio delay line: a small SRAM responder model, a vector
// table, hand-written corner sequences and a randomized run against a queue model.
module tb_team_06_sram_audio_delay;

    localparam int BASE  = 100;
    localparam int DEPTH = 2;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    sample_in = '0;
    logic          sample_valid = 1'b0;
    logic [PW-1:0] delay_samples = '0;
    logic [7:0]    sample_out;
    logic          out_valid;
    logic          overflow;
    logic [31:0]   sram_address;
    logic [31:0]   sram_write_data;
    logic          sram_write_en;
    logic          sram_read_en;
    logic [3:0]    sram_byte_select;
    logic [31:0]   sram_read_data;
    logic          sram_busy;

    int errors = 0;
    int checks = 0;
    int cycleCnt = 0;

    always #5 clk = ~clk;

    team_06_sram_audio_delay #(
        .BASE_WORD   (BASE),
        .DEPTH_WORDS (DEPTH),
        .PTR_W       (PW)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .enable           (enable),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .delay_samples    (delay_samples),
        .sample_out       (sample_out),
        .out_valid        (out_valid),
        .overflow         (overflow),
        .sram_address     (sram_address),
        .sram_write_data  (sram_write_data),
        .sram_write_en    (sram_write_en),
        .sram_read_en     (sram_read_en),
        .sram_byte_select (sram_byte_select),
        .sram_read_data   (sram_read_data),
        .sram_busy        (sram_busy)
    );

    // Responder: busy for one cycle per access, writes commit as busy ends.
    logic [31:0] mem [0:8191];
    logic        memClear = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) sram_busy <= 1'b0;
        else       sram_busy <= (sram_write_en || sram_read_en) && !sram_busy;
    end

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 32'h0;
        end else if (sram_busy && sram_write_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_byte_select[b]) mem[sram_address[12:0]][8*b +: 8] <= sram_write_data[8*b +: 8];
        end
    end

    assign sram_read_data = mem[sram_address[12:0]];

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Bus protocol watcher: never both enables, hold until busy, drop right after busy.
    logic        pWe = 1'b0, pRe = 1'b0, pBusy = 1'b0;
    logic [31:0] pAddr = '0, pData = '0;
    logic [3:0]  pBe = '0;
    logic [3:0]  lastWrBe = '0;
    logic [31:0] lastWrAddr = '0;

    always @(negedge clk) begin
        if (nrst) begin
            checkOutput("protoBothEn", {31'b0, sram_write_en && sram_read_en}, 32'h0);
            if ((pWe || pRe) && !pBusy) begin
                checkOutput("protoHold", {30'b0, sram_write_en, sram_read_en}, {30'b0, pWe, pRe});
                checkOutput("protoAddr", sram_address, pAddr);
                checkOutput("protoBe", {28'b0, sram_byte_select}, {28'b0, pBe});
                if (pWe) checkOutput("protoData", sram_write_data, pData);
            end
            if (pWe && pBusy) checkOutput("protoWrDrop", {31'b0, sram_write_en}, 32'h0);
            if (pRe && pBusy) checkOutput("protoRdDrop", {31'b0, sram_read_en}, 32'h0);
        end
        if (sram_write_en) begin
            lastWrBe   <= sram_byte_select;
            lastWrAddr <= sram_address;
        end
        pWe   <= sram_write_en;
        pRe   <= sram_read_en;
        pBusy <= sram_busy;
        pAddr <= sram_address;
        pData <= sram_write_data;
        pBe   <= sram_byte_select;
    end

    // Randomized-run scoreboard: each accepted sample owes one output at a known cycle.
    typedef struct { int cyc; logic [7:0] val; } exp_t;
    exp_t expQ[$];
    bit   randActive = 1'b0;

    always @(negedge clk) begin
        if (randActive && out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("randExtraPulse", 32'h1, 32'h0);
            end else begin
                checkOutput("randValue", {24'b0, sample_out}, {24'b0, expQ[0].val});
                checkOutput("randCycle", cycleCnt, expQ[0].cyc);
                void'(expQ.pop_front());
            end
        end
    end

    task automatic resetDut();
        nrst = 1'b0;
        enable = 1'b0;
        sample_valid = 1'b0;
        memClear = 1'b1;
        repeat (2) @(negedge clk);
        memClear = 1'b0;
        nrst = 1'b1;
        enable = 1'b1;
        @(negedge clk);
    endtask

    // One strobe, then wait (bounded) for the matching out_valid pulse.
    task automatic applyStimulus(input logic [7:0] s, input logic [PW-1:0] d,
                                 output logic [7:0] got, output int lat);
        @(negedge clk);
        delay_samples = d;
        sample_in = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_in = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        got = sample_out;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]    sampleIn;
        logic [PW-1:0] delay;
        logic [7:0]    expOut;
        logic [3:0]    expBe;
        logic [31:0]   expAddr;
        bit            resetBefore;
    } vec_t;

    vec_t vecs[32];

    initial begin
        logic [7:0] got;
        logic [7:0] vals[2];
        logic [7:0] hist[$];
        int lat, pulses, lastStart, start, k, d, gap, t;
        bit dropped;

        // Vector table: byte lanes, a 4-sample delay, then wrap through the 8-byte ring.
        for (int i = 0; i < 4; i++)
            vecs[i] = '{8'(8'h11 * (i + 1)), PW'(0), 8'(8'h11 * (i + 1)), 4'(1 << i), BASE, i == 0};
        for (int i = 0; i < 16; i++)
            vecs[4 + i] = '{8'(i + 1), PW'(4), (i >= 4) ? 8'(i - 3) : 8'h00,
                            4'(1 << (i % 4)), BASE + (i % 8) / 4, i == 0};
        for (int i = 0; i < 12; i++)
            vecs[20 + i] = '{8'(8'hA0 + i), PW'(7), (i >= 7) ? 8'(8'hA0 + i - 7) : 8'h00,
                             4'(1 << (i % 4)), BASE + (i % 8) / 4, i == 0};

        // Reset holds every output low whatever the inputs do.
        memClear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enable = 1'($urandom);
            sample_valid = 1'($urandom);
            sample_in = 8'($urandom);
            delay_samples = PW'($urandom);
            @(negedge clk);
            checkOutput("resetOutputs",
                        {22'b0, out_valid, overflow, sram_write_en, sram_read_en, sram_byte_select, sample_out} |
                        sram_address | sram_write_data, 32'h0);
        end
        memClear = 1'b0;

        // First sample after reset: exact latency and value.
        resetDut();
        applyStimulus(8'h5A, PW'(0), got, lat);
        checkOutput("firstLatency", lat, 5);
        checkOutput("firstValue", {24'b0, got}, 32'h5A);

        for (int i = 0; i < 32; i++) begin
            if (vecs[i].resetBefore) resetDut();
            applyStimulus(vecs[i].sampleIn, vecs[i].delay, got, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, 5);
            checkOutput($sformatf("vec%0d_out", i), {24'b0, got}, {24'b0, vecs[i].expOut});
            checkOutput($sformatf("vec%0d_be", i), {28'b0, lastWrBe}, {28'b0, vecs[i].expBe});
            checkOutput($sformatf("vec%0d_addr", i), lastWrAddr, vecs[i].expAddr);
            if (i == 3) checkOutput("laneWord", mem[BASE], 32'h44332211);
        end

        // Three back-to-back strobes: two serviced, the third dropped.
        resetDut();
        delay_samples = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample_in = 8'(8'h61 + i);
            sample_valid = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        pulses = 0;
        vals[0] = '0;
        vals[1] = '0;
        repeat (20) begin
            if (out_valid) begin
                if (pulses < 2) vals[pulses] = sample_out;
                pulses++;
            end
            @(negedge clk);
        end
        checkOutput("ovfPulses", pulses, 2);
        checkOutput("ovfFirst", {24'b0, vals[0]}, 32'h61);
        checkOutput("ovfSecond", {24'b0, vals[1]}, 32'h62);
        checkOutput("ovfSticky", {31'b0, overflow}, 32'h1);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("ovfCleared", {31'b0, overflow}, 32'h0);

        // Enable falling mid-transaction still completes the access.
        enable = 1'b1;
        @(negedge clk);
        sample_in = 8'h77;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        enable = 1'b0;
        pulses = 0;
        got = '0;
        repeat (15) begin
            if (out_valid) begin
                pulses++;
                got = sample_out;
            end
            @(negedge clk);
        end
        checkOutput("enFallPulses", pulses, 1);
        checkOutput("enFallValue", {24'b0, got}, 32'h77);

        // With enable low, strobes are ignored.
        sample_in = 8'h88;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        pulses = 0;
        repeat (12) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        checkOutput("disabledPulses", pulses, 0);

        // Randomized run against a server-with-one-slot model.
        resetDut();
        d = int'($urandom_range(0, 7));
        delay_samples = PW'(d);
        lastStart = -100;
        dropped = 1'b0;
        randActive = 1'b1;
        for (int n = 0; n < 40; n++) begin
            gap = int'($urandom_range(1, 7));
            t = cycleCnt;
            sample_in = 8'($urandom);
            sample_valid = 1'b1;
            if (lastStart <= t) begin
                start = (t > lastStart + 5) ? t : lastStart + 5;
                k = hist.size();
                hist.push_back(sample_in);
                expQ.push_back('{start + 5, (k >= d) ? hist[k - d] : 8'h00});
                lastStart = start;
            end else begin
                dropped = 1'b1;
            end
            @(negedge clk);
            sample_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        randActive = 1'b0;
        checkOutput("randDrained", expQ.size(), 0);
        checkOutput("randOverflow", {31'b0, overflow}, {31'b0, dropped});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
